// File: rtl/cache_memory_arbiter.sv
// Shares one main-memory port between the I-cache and D-cache miss engines.
// Grants one requester at a time and runs an aligned BURST_LEN-beat line burst.
module cache_memory_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iIReq,
  input  logic [ADDR_W-1:0] iIAddr,
  output logic [DATA_W-1:0] oIRdData,
  output logic              oIRdValid,
  output logic              oIDone,
  input  logic              iDReq,
  input  logic              iDWrite,
  input  logic [ADDR_W-1:0] iDAddr,
  input  logic [DATA_W-1:0] iDWrData,
  output logic              oDWrNext,
  output logic [DATA_W-1:0] oDRdData,
  output logic              oDRdValid,
  output logic              oDDone,
  output logic              oMemReq,
  output logic              oMemWrite,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemWrData,
  input  logic              iMemAck,
  input  logic [DATA_W-1:0] iMemRdData,
  output logic              oBusy
);

  localparam int BW = $clog2(BURST_LEN);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]        r_state;
  logic              r_own_d;
  logic              r_write;
  logic              r_last_d;
  logic [ADDR_W-1:0] r_base;
  logic [BW-1:0]     r_beat;

  logic              w_burst;
  logic              w_done;
  logic              w_busy;
  logic              w_any_req;
  logic              w_pick_d;
  logic              w_last_beat;
  logic [ADDR_W-1:0] w_req_addr;
  logic [ADDR_W-1:0] w_align_mask;

  assign w_burst      = (r_state == S_BURST);
  assign w_done       = (r_state == S_DONE);
  assign w_busy       = w_burst | w_done;
  assign w_any_req    = iIReq | iDReq;
  // D wins only when alone, or on a tie when I was served last.
  assign w_pick_d     = iDReq & (~iIReq | ~r_last_d);
  assign w_last_beat  = (r_beat == BW'(BURST_LEN - 1));
  assign w_req_addr   = w_pick_d ? iDAddr : iIAddr;
  assign w_align_mask = ~ADDR_W'(BURST_LEN - 1);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state  <= S_IDLE;
      r_own_d  <= 1'b0;
      r_write  <= 1'b0;
      r_last_d <= 1'b1;
      r_base   <= '0;
      r_beat   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_own_d <= w_pick_d;
            r_write <= w_pick_d & iDWrite;
            r_base  <= w_req_addr & w_align_mask;
            r_beat  <= '0;
            r_state <= S_BURST;
          end
        end
        S_BURST: begin
          if (iMemAck) begin
            if (w_last_beat) r_state <= S_DONE;
            else             r_beat  <= r_beat + 1'b1;
          end
        end
        S_DONE: begin
          r_last_d <= r_own_d;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Base is aligned, so the beat index simply replaces the low address bits.
  assign oMemReq    = w_burst;
  assign oMemWrite  = w_burst & r_write;
  assign oMemAddr   = w_burst ? {r_base[ADDR_W-1:BW], r_beat} : '0;
  assign oMemWrData = (w_busy & r_own_d & r_write) ? iDWrData : '0;

  assign oIRdData  = iMemRdData;
  assign oDRdData  = iMemRdData;
  assign oIRdValid = w_burst & ~r_own_d & ~r_write & iMemAck;
  assign oDRdValid = w_burst &  r_own_d & ~r_write & iMemAck;
  assign oDWrNext  = w_burst &  r_own_d &  r_write & iMemAck;

  assign oIDone = w_done & ~r_own_d;
  assign oDDone = w_done &  r_own_d;
  assign oBusy  = w_busy;

endmodule

// File: tb/tb_cache_memory_arbiter.sv
// Scoreboard bench for cache_memory_arbiter: expected beats and done pulses are
// queued when a request is raised and retired as the memory port and done lines fire.
module tb_cache_memory_arbiter;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iIReq;
  logic [31:0] iIAddr;
  logic [31:0] oIRdData;
  logic        oIRdValid;
  logic        oIDone;
  logic        iDReq;
  logic        iDWrite;
  logic [31:0] iDAddr;
  logic [31:0] iDWrData;
  logic        oDWrNext;
  logic [31:0] oDRdData;
  logic        oDRdValid;
  logic        oDDone;
  logic        oMemReq;
  logic        oMemWrite;
  logic [31:0] oMemAddr;
  logic [31:0] oMemWrData;
  logic        iMemAck = 1'b0;
  logic [31:0] iMemRdData;
  logic        oBusy;

  cache_memory_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_LEN(4)) dut (
    .iClk(iClk), .iRst(iRst),
    .iIReq(iIReq), .iIAddr(iIAddr), .oIRdData(oIRdData), .oIRdValid(oIRdValid), .oIDone(oIDone),
    .iDReq(iDReq), .iDWrite(iDWrite), .iDAddr(iDAddr), .iDWrData(iDWrData), .oDWrNext(oDWrNext),
    .oDRdData(oDRdData), .oDRdValid(oDRdValid), .oDDone(oDDone),
    .oMemReq(oMemReq), .oMemWrite(oMemWrite), .oMemAddr(oMemAddr), .oMemWrData(oMemWrData),
    .iMemAck(iMemAck), .iMemRdData(iMemRdData), .oBusy(oBusy)
  );

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic        d;
    logic [31:0] data;
  } beat_t;

  beat_t sb[$];
  bit    done_q[$];
  int    tests = 0;
  int    fails = 0;
  int    beats_seen = 0;
  int    ack_mode = 0;  // 0 = ack every cycle, 1 = even cycles only, 2 = never

  // Memory returns a fixed function of the address; the D-cache offers word k at pointer k.
  logic [31:0] wr_ptr;
  assign iMemRdData = oMemAddr - 32'h60;
  assign iDWrData   = 32'hD000_0000 + wr_ptr;
  always @(posedge iClk) begin
    if (!iDReq)        wr_ptr <= 32'd0;
    else if (oDWrNext) wr_ptr <= wr_ptr + 32'd1;
  end

  function automatic bit ack_at(input int t);
    if (ack_mode == 0) return 1'b1;
    if (ack_mode == 1) return (t % 2) == 0;
    return 1'b0;
  endfunction

  initial begin
    forever begin
      @(posedge iClk);
      #2 iMemAck = ack_at(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cycle in which the done pulse should appear for a burst whose first beat cycle is 'start'.
  function automatic int done_cycle(input int start);
    int t;
    int n;
    t = start;
    n = 0;
    for (int k = 0; k < 1000; k++) begin
      if (ack_at(t)) n++;
      if (n == 4) return t + 1;
      t++;
    end
    return -1;
  endfunction

  task automatic push_burst(input bit d, input bit wr, input logic [31:0] addr);
    logic [31:0] base;
    beat_t e;
    base = addr & ~32'h3;
    for (int k = 0; k < 4; k++) begin
      e.addr = base + k;
      e.wr   = wr;
      e.d    = d;
      e.data = wr ? (32'hD000_0000 + k) : (base + k - 32'h60);
      sb.push_back(e);
    end
    done_q.push_back(d);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_flags"}, {oMemReq, oMemWrite, oIRdValid, oDRdValid, oIDone, oDDone, oDWrNext, oBusy}, 0);
    check_eq({tag, "_addr"}, oMemAddr, 0);
    check_eq({tag, "_wdata"}, oMemWrData, 0);
  endtask

  task automatic wait_done(input bit d, output int t);
    t = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge iClk);
      if (d ? oDDone : oIDone) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check_eq(d ? "d_done_timeout" : "i_done_timeout", 0, 1);
  endtask

  task automatic run_single(input bit d, input bit wr, input logic [31:0] addr, input string tag);
    int c0;
    int t;
    @(posedge iClk);
    #1;
    c0 = cyc;
    if (d) begin iDAddr = addr; iDWrite = wr; iDReq = 1'b1; end
    else   begin iIAddr = addr; iIReq = 1'b1; end
    push_burst(d, wr, addr);
    wait_done(d, t);
    check_eq({tag, "_done_cyc"}, t, done_cycle(c0 + 1));
    @(posedge iClk);
    #1;
    if (d) iDReq = 1'b0; else iIReq = 1'b0;
    @(negedge iClk);
    check_eq({tag, "_busy_after"}, oBusy, 0);
  endtask

  // Retire scoreboard entries as beats are accepted and done pulses fire.
  initial begin
    beat_t e;
    bit dd;
    forever begin
      @(negedge iClk);
      if (oMemReq && iMemAck) begin
        if (sb.size() == 0) begin
          check_eq("beat_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          beats_seen++;
          check_eq("beat_addr", oMemAddr, e.addr);
          check_eq("beat_write", oMemWrite, e.wr);
          if (e.wr) begin
            check_eq("wb_data", oMemWrData, e.data);
            check_eq("wb_next", oDWrNext, 1);
            check_eq("wb_rd_valid", {oIRdValid, oDRdValid}, 0);
          end else begin
            check_eq("fill_data", e.d ? oDRdData : oIRdData, e.data);
            check_eq("fill_valid", {oIRdValid, oDRdValid}, e.d ? 2'b01 : 2'b10);
            check_eq("fill_wr_next", oDWrNext, 0);
          end
        end
      end else begin
        check_eq("no_ack_strobes", {oIRdValid, oDRdValid, oDWrNext}, 0);
        if (oMemReq && sb.size() > 0) begin
          check_eq("stall_addr", oMemAddr, sb[0].addr);
          check_eq("stall_write", oMemWrite, sb[0].wr);
        end
      end
      if (oIDone || oDDone) begin
        if (done_q.size() == 0) begin
          check_eq("done_unexpected", {oIDone, oDDone}, 0);
        end else begin
          dd = done_q.pop_front();
          check_eq("done_owner", {oIDone, oDDone}, dd ? 2'b01 : 2'b10);
        end
      end
    end
  end

  initial begin
    int c0;
    int t;
    int t2;
    int b0;
    iRst = 1'b1; iIReq = 1'b0; iDReq = 1'b0; iDWrite = 1'b0; iIAddr = '0; iDAddr = '0;
    repeat (3) @(posedge iClk);
    #1 iRst = 1'b0;
    @(negedge iClk);
    check_zero("reset");

    run_single(1'b0, 1'b0, 32'h103, "i_fill");
    run_single(1'b1, 1'b1, 32'h208, "d_wb");

    // Tie straight out of reset: I first, then D with no idle gap, then I wins the next tie.
    @(posedge iClk); #1 iRst = 1'b1;
    @(posedge iClk); #1 iRst = 1'b0;
    for (int r = 0; r < 2; r++) begin
      @(posedge iClk);
      #1;
      c0 = cyc;
      iIAddr = (r == 0) ? 32'h40 : 32'h60;
      iDAddr = (r == 0) ? 32'h54 : 32'h72;
      iDWrite = (r == 1);
      iIReq = 1'b1;
      iDReq = 1'b1;
      push_burst(1'b0, 1'b0, iIAddr);
      push_burst(1'b1, iDWrite, iDAddr);
      wait_done(1'b0, t);
      check_eq("tie_i_done_cyc", t, done_cycle(c0 + 1));
      @(posedge iClk); #1 iIReq = 1'b0;
      wait_done(1'b1, t2);
      check_eq("b2b_d_done_cyc", t2, done_cycle(t + 2));
      @(posedge iClk); #1 iDReq = 1'b0;
    end

    ack_mode = 1;
    run_single(1'b0, 1'b0, 32'h0A2, "i_stall");
    run_single(1'b1, 1'b1, 32'h0B0, "d_wb_stall");
    ack_mode = 0;

    // Reset in the middle of a D fill abandons it without a done pulse.
    @(posedge iClk);
    #1;
    b0 = beats_seen;
    iDAddr = 32'h302; iDWrite = 1'b0; iDReq = 1'b1;
    push_burst(1'b1, 1'b0, 32'h302);
    for (int n = 0; n < 50; n++) begin
      @(posedge iClk);
      if (beats_seen - b0 >= 2) break;
    end
    check_eq("midrst_two_beats", (beats_seen - b0 >= 2), 1);
    #1;
    ack_mode = 2; iRst = 1'b1; iDReq = 1'b0;
    @(posedge iClk);
    #1;
    iRst = 1'b0; ack_mode = 0;
    sb.delete();
    done_q.delete();
    @(negedge iClk);
    check_zero("midrst");
    repeat (4) @(negedge iClk);
    run_single(1'b1, 1'b0, 32'h301, "d_restart");

    // D request arrives while I is bursting; it waits and starts in the first IDLE cycle.
    @(posedge iClk);
    #1;
    c0 = cyc;
    iIAddr = 32'h400; iIReq = 1'b1;
    push_burst(1'b0, 1'b0, 32'h400);
    repeat (2) @(posedge iClk);
    #1;
    iDAddr = 32'h500; iDWrite = 1'b1; iDReq = 1'b1;
    push_burst(1'b1, 1'b1, 32'h500);
    wait_done(1'b0, t);
    check_eq("busy_i_done_cyc", t, done_cycle(c0 + 1));
    @(posedge iClk); #1 iIReq = 1'b0;
    wait_done(1'b1, t2);
    check_eq("busy_d_done_cyc", t2, done_cycle(t + 2));
    @(posedge iClk); #1 iDReq = 1'b0;
    @(negedge iClk);
    check_eq("final_busy", oBusy, 0);

    repeat (3) @(negedge iClk);
    check_eq("sb_leftover", sb.size(), 0);
    check_eq("done_leftover", done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
